// File: rtl/rv32i_program_encoder.sv
// rv32i_program_encoder
// Packs one instruction per handshake into an RV32I 32-bit word and streams the
// words into instruction memory at consecutive word addresses from BASE_ADDR.
// The instruction is given as a mnemonic code plus rd/rs1/rs2/imm fields.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle pulse: flush pipeline, rewind address, clear counts/flags
//   in_valid/in_ready   instruction handshake (transfer when both high)
//   in_mnem             mnemonic code 0..37 (>= 38 is illegal)
//   in_rd/rs1/rs2       register fields
//   in_imm              immediate in byte-offset/value form
//   mem_we/mem_ready    memory write handshake (write completes when both high)
//   mem_addr/mem_wdata  word address and encoded instruction of the pending write
//   instr_count         words written since start
//   err_illegal         1-cycle pulse after an illegal mnemonic was accepted and dropped
//   prog_full           sticky once DEPTH legal entries have been issued
//
// Pipeline: S1 holds the freshly encoded word, S2 drives mem_*. S2 holds while
// the memory stalls, and S1 only refills when S2 can move on.

module rv32i_program_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_mnem,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              prog_full
);

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_ZERO,
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_t;

    fmt_t        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [31:0] enc_word;

    logic              s1_v;
    logic [31:0]       s1_word;
    logic              s2_v;
    logic [ADDR_W:0]   issued;

    logic fire;
    logic legal_fire;
    logic s2_free;
    logic wr_done;

    // Mnemonic decode: select format and the fixed opcode/funct fields.
    always_comb begin
        fmt    = FMT_ZERO;
        opcode = 7'b0;
        funct3 = 3'b0;
        funct7 = 7'b0;
        legal  = 1'b1;
        case (in_mnem)
            6'd0:  fmt = FMT_ZERO;
            6'd1:  begin fmt = FMT_U; opcode = OP_LUI;   end
            6'd2:  begin fmt = FMT_U; opcode = OP_AUIPC; end
            6'd3:  begin fmt = FMT_J; opcode = OP_JAL;   end
            6'd4:  begin fmt = FMT_I; opcode = OP_JALR;  end
            6'd5:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b000; end
            6'd6:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b001; end
            6'd7:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b100; end
            6'd8:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b101; end
            6'd9:  begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b110; end
            6'd10: begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b111; end
            6'd11: begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b000; end
            6'd12: begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b001; end
            6'd13: begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b010; end
            6'd14: begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b100; end
            6'd15: begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b101; end
            6'd16: begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b000; end
            6'd17: begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b001; end
            6'd18: begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b010; end
            6'd19: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b000; end
            6'd20: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b010; end
            6'd21: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b011; end
            6'd22: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b100; end
            6'd23: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b110; end
            6'd24: begin fmt = FMT_I;  opcode = OP_IMM; funct3 = 3'b111; end
            6'd25: begin fmt = FMT_SH; opcode = OP_IMM; funct3 = 3'b001; end
            6'd26: begin fmt = FMT_SH; opcode = OP_IMM; funct3 = 3'b101; end
            6'd27: begin fmt = FMT_SH; opcode = OP_IMM; funct3 = 3'b101; funct7 = F7_ALT; end
            6'd28: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b000; end
            6'd29: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b000; funct7 = F7_ALT; end
            6'd30: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b001; end
            6'd31: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b010; end
            6'd32: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b011; end
            6'd33: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b100; end
            6'd34: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b101; end
            6'd35: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b101; funct7 = F7_ALT; end
            6'd36: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b110; end
            6'd37: begin fmt = FMT_R; opcode = OP_REG; funct3 = 3'b111; end
            default: legal = 1'b0;
        endcase
    end

    // Field packing; fields not used by a format stay zero.
    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R:  enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, opcode};
            FMT_I:  enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, opcode};
            FMT_SH: enc_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, opcode};
            FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], opcode};
            FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                                in_imm[4:1], in_imm[11], opcode};
            FMT_U:  enc_word = {in_imm[31:12], in_rd, opcode};
            FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, opcode};
            default: enc_word = 32'h0;
        endcase
    end

    assign mem_we     = s2_v;
    assign s2_free    = !s2_v || mem_ready;
    assign wr_done    = s2_v && mem_ready;
    // rst_n keeps in_ready low while reset is held; start blocks same-cycle accepts.
    assign in_ready   = rst_n && !start && !prog_full && (!s1_v || !s2_v || mem_ready);
    assign fire       = in_valid && in_ready;
    assign legal_fire = fire && legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_word     <= 32'h0;
            s2_v        <= 1'b0;
            mem_wdata   <= 32'h0;
            mem_addr    <= BASE;
            instr_count <= '0;
            issued      <= '0;
            prog_full   <= 1'b0;
            err_illegal <= 1'b0;
        end else if (start) begin
            // A write pending in S2 is discarded without being counted.
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            mem_wdata   <= 32'h0;
            mem_addr    <= BASE;
            instr_count <= '0;
            issued      <= '0;
            prog_full   <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= fire && !legal;

            if (s2_free) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    mem_wdata <= s1_word;
                end
            end

            if (!s1_v || s2_free) begin
                s1_v <= legal_fire;
                if (legal_fire) begin
                    s1_word <= enc_word;
                end
            end

            if (wr_done) begin
                instr_count <= instr_count + ONE_C;
                if (mem_addr != {ADDR_W{1'b1}}) begin
                    mem_addr <= mem_addr + 1'b1;
                end
            end

            if (legal_fire) begin
                issued <= issued + ONE_C;
                if (issued + ONE_C == DEPTH_C) begin
                    prog_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_program_encoder.sv
`timescale 1ns/1ps

module tb_rv32i_program_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_mnem;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   instr_count;
    logic              err_illegal;
    logic              prog_full;

    rv32i_program_encoder #(
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mnem(in_mnem),
        .in_rd(in_rd),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .in_imm(in_imm),
        .mem_we(mem_we),
        .mem_ready(mem_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .instr_count(instr_count),
        .err_illegal(err_illegal),
        .prog_full(prog_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+31:0] sb_q[$];
    logic [ADDR_W-1:0]  exp_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed write must match the oldest pushed entry.
    always @(negedge clk) begin
        #2;
        if (rst_n && mem_we && mem_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {24'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+31:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", {24'h0, mem_addr}, {24'h0, e[ADDR_W+31:32]});
                chk("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [5:0] m, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp, input bit legal);
        int n;
        in_valid = 1'b1;
        in_mnem  = m;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            in_valid = 1'b0;
        end else begin
            if (legal) begin
                sb_q.push_back({exp_addr, exp});
                exp_addr = exp_addr + 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mem_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb_q.size(), 32'h0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_q.delete();
        exp_addr = '0;
    endtask

    logic [5:0]  st_m   [3] = '{6'd28, 6'd29, 6'd19};
    logic [4:0]  st_rd  [3] = '{5'd1, 5'd3, 5'd5};
    logic [4:0]  st_rs1 [3] = '{5'd2, 5'd0, 5'd4};
    logic [4:0]  st_rs2 [3] = '{5'd3, 5'd3, 5'd0};
    logic [31:0] st_exp [3] = '{32'h003100B3, 32'h403001B3, 32'h00020293};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_mnem   = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        mem_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_count", {23'h0, instr_count}, 32'h0);
        chk("rst_flags", {30'h0, err_illegal, prog_full}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);

        // ADDI x5,x4,0 with junk rs2: latency and encoding.
        send(6'd19, 5'd5, 5'd4, 5'd31, 32'h0, 32'h00020293, 1'b1);
        idle();
        chk("lat_n1_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        chk("lat_n2_we", {31'h0, mem_we}, 32'h1);
        chk("lat_n2_addr", {24'h0, mem_addr}, 32'h0);
        chk("lat_n2_data", mem_wdata, 32'h00020293);
        @(negedge clk);
        chk("addi_count", {23'h0, instr_count}, 32'h1);

        // Back-to-back SUB, SB (junk rd), JAL.
        do_start();
        send(6'd29, 5'd3, 5'd0, 5'd3, 32'h0, 32'h403001B3, 1'b1);
        send(6'd16, 5'd9, 5'd1, 5'd5, 32'd6, 32'h00508323, 1'b1);
        send(6'd3, 5'd20, 5'd7, 5'd7, 32'd8, 32'h00800A6F, 1'b1);
        idle();
        drain("b2b_drain");
        chk("b2b_count", {23'h0, instr_count}, 32'h3);
        chk("b2b_addr", {24'h0, mem_addr}, 32'h3);

        // Branch/upper/load/shift, filling DEPTH=4.
        do_start();
        send(6'd5, 5'd7, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b1);
        send(6'd1, 5'd15, 5'd0, 5'd0, 32'h03F0A000, 32'h03F0A7B7, 1'b1);
        send(6'd13, 5'd8, 5'd2, 5'd9, 32'hFFFF_FFFC, 32'hFFC12403, 1'b1);
        send(6'd27, 5'd6, 5'd7, 5'd0, 32'h0000_0003, 32'h4033D313, 1'b1);
        in_valid = 1'b1;
        in_mnem  = 6'd28;
        #1;
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        chk("full_flag", {31'h0, prog_full}, 32'h1);
        @(negedge clk);
        idle();
        drain("full_drain");
        chk("full_count", {23'h0, instr_count}, 32'h4);
        chk("full_sticky", {30'h0, prog_full, in_ready}, 32'h2);

        // Memory stall: 3 offered over 5 stalled cycles.
        do_start();
        chk("start_clr_full", {31'h0, prog_full}, 32'h0);
        mem_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                in_mnem  = st_m[idx];
                in_rd    = st_rd[idx];
                in_rs1   = st_rs1[idx];
                in_rs2   = st_rs2[idx];
                in_imm   = 32'h0;
                #1;
                if (in_ready) begin
                    sb_q.push_back({exp_addr, st_exp[idx]});
                    exp_addr = exp_addr + 1'b1;
                    idx++;
                end
            end
            @(negedge clk);
            if (c == 2) chk("stall_s2_early", mem_wdata, st_exp[0]);
        end
        idle();
        chk("stall_accepts", idx, 32'd2);
        chk("stall_we", {31'h0, mem_we}, 32'h1);
        chk("stall_s2_stable", mem_wdata, st_exp[0]);
        chk("stall_addr", {24'h0, mem_addr}, 32'h0);
        mem_ready = 1'b1;
        send(st_m[2], st_rd[2], st_rs1[2], st_rs2[2], 32'h0, st_exp[2], 1'b1);
        idle();
        drain("stall_drain");
        chk("stall_count", {23'h0, instr_count}, 32'h3);

        // Illegal mnemonic.
        do_start();
        send(6'd45, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 1'b0);
        idle();
        chk("ill_pulse", {31'h0, err_illegal}, 32'h1);
        chk("ill_no_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        chk("ill_pulse_end", {31'h0, err_illegal}, 32'h0);
        chk("ill_no_we2", {31'h0, mem_we}, 32'h0);
        chk("ill_addr", {24'h0, mem_addr}, 32'h0);
        chk("ill_count", {23'h0, instr_count}, 32'h0);
        // Three more legal entries must not fill DEPTH=4 (illegal not issued).
        send(6'd33, 5'd9, 5'd10, 5'd11, 32'h0, 32'h00B544B3, 1'b1);
        send(6'd33, 5'd9, 5'd10, 5'd11, 32'h0, 32'h00B544B3, 1'b1);
        send(6'd33, 5'd9, 5'd10, 5'd11, 32'h0, 32'h00B544B3, 1'b1);
        idle();
        chk("ill_not_full", {31'h0, prog_full}, 32'h0);
        drain("ill_drain");

        // start while S2 is stalled.
        do_start();
        mem_ready = 1'b0;
        send(6'd28, 5'd1, 5'd2, 5'd3, 32'h0, 32'h003100B3, 1'b1);
        idle();
        @(negedge clk);
        chk("flush_pending_we", {31'h0, mem_we}, 32'h1);
        start    = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("flush_ready_blk", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        exp_addr = '0;
        chk("flush_we", {31'h0, mem_we}, 32'h0);
        chk("flush_count", {23'h0, instr_count}, 32'h0);
        chk("flush_addr", {24'h0, mem_addr}, 32'h0);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_no_write", {31'h0, mem_we}, 32'h0);
        send(6'd33, 5'd9, 5'd10, 5'd11, 32'h0, 32'h00B544B3, 1'b1);
        idle();
        drain("flush_drain");
        chk("flush_new_count", {23'h0, instr_count}, 32'h1);
        chk("flush_new_addr", {24'h0, mem_addr}, 32'h1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
